// File: rtl/phase_measure_if.sv
// Bus between a PPS phase meter and its user:
// PPS inputs, enable, and the measurement results.
interface phase_measure_if;
   logic        GPS_PPS;
   logic        Local_PPS;
   logic        Meas_En;
   logic [23:0] Measure_Phase;
   logic        Measure_Done;
   logic        Measure_Timeout;

   modport master (
      output GPS_PPS,
      output Local_PPS,
      output Meas_En,
      input  Measure_Phase,
      input  Measure_Done,
      input  Measure_Timeout
   );

   modport slave (
      input  GPS_PPS,
      input  Local_PPS,
      input  Meas_En,
      output Measure_Phase,
      output Measure_Done,
      output Measure_Timeout
   );
endinterface

// File: rtl/phase_measure.sv
// Measures the signed offset between GPS and local PPS
// rising edges in CLK_SYS cycles (positive = GPS leads).
module phase_measure #(
   parameter logic [23:0] TIMEOUT = 24'd5000000
) (
   input  logic           CLK_SYS,
   input  logic           CLK_RST,
   phase_measure_if.slave pm
);

   typedef enum logic [1:0] {
      IDLE,
      GPS_FIRST,
      LOCAL_FIRST
   } state_t;

   state_t      r_state;
   state_t      w_state_nx;
   logic [1:0]  r_gps_sync;
   logic [1:0]  r_loc_sync;
   logic        r_gps_dly;
   logic        r_loc_dly;
   logic        r_gps_arm;
   logic        r_loc_arm;
   logic [1:0]  r_vld;
   logic [23:0] r_cnt;
   logic [23:0] w_cnt_nx;
   logic [23:0] w_cnt_inc;
   logic [23:0] r_phase;
   logic [23:0] w_phase_nx;
   logic        r_done;
   logic        w_done_nx;
   logic        r_tmo;
   logic        w_tmo_nx;
   logic        w_tmo_hit;
   logic        w_gps_rise;
   logic        w_loc_rise;

   // Arm only after a real low has been seen through the
   // synchronizer, so a PPS held high across reset is no edge.
   always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
      if (!CLK_RST) begin
         r_gps_sync <= 2'b00;
         r_loc_sync <= 2'b00;
         r_gps_dly  <= 1'b0;
         r_loc_dly  <= 1'b0;
         r_gps_arm  <= 1'b0;
         r_loc_arm  <= 1'b0;
         r_vld      <= 2'b00;
      end else begin
         r_gps_sync <= {r_gps_sync[0], pm.GPS_PPS};
         r_loc_sync <= {r_loc_sync[0], pm.Local_PPS};
         r_gps_dly  <= r_gps_sync[1];
         r_loc_dly  <= r_loc_sync[1];
         r_vld      <= {r_vld[0], 1'b1};
         if (r_vld[1] && !r_gps_sync[1])
            r_gps_arm <= 1'b1;
         if (r_vld[1] && !r_loc_sync[1])
            r_loc_arm <= 1'b1;
      end
   end

   assign w_gps_rise = r_gps_arm & r_gps_sync[1] & ~r_gps_dly;
   assign w_loc_rise = r_loc_arm & r_loc_sync[1] & ~r_loc_dly;

   always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
      if (!CLK_RST) begin
         r_state <= IDLE;
         r_cnt   <= 24'd0;
         r_phase <= 24'd0;
         r_done  <= 1'b0;
         r_tmo   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_phase <= w_phase_nx;
         r_done  <= w_done_nx;
         r_tmo   <= w_tmo_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_inc  = r_cnt + 24'd1;
      w_cnt_nx   = w_cnt_inc;
      w_phase_nx = r_phase;
      w_done_nx  = 1'b0;
      w_tmo_nx   = 1'b0;
      w_tmo_hit  = (w_cnt_inc >= TIMEOUT);
      if (!pm.Meas_En) begin
         w_state_nx = IDLE;
         w_cnt_nx   = 24'd0;
      end else begin
         unique case (r_state)
            IDLE: begin
               w_cnt_nx = 24'd0;
               if (w_gps_rise && w_loc_rise) begin
                  w_phase_nx = 24'd0;
                  w_done_nx  = 1'b1;
               end else if (w_gps_rise) begin
                  w_state_nx = GPS_FIRST;
               end else if (w_loc_rise) begin
                  w_state_nx = LOCAL_FIRST;
               end
            end
            GPS_FIRST: begin
               if (w_loc_rise) begin
                  w_phase_nx = w_cnt_inc;
                  w_done_nx  = 1'b1;
                  w_state_nx = IDLE;
                  w_cnt_nx   = 24'd0;
               end else if (w_gps_rise) begin
                  w_cnt_nx   = 24'd0;
               end else if (w_tmo_hit) begin
                  w_tmo_nx   = 1'b1;
                  w_state_nx = IDLE;
                  w_cnt_nx   = 24'd0;
               end
            end
            LOCAL_FIRST: begin
               if (w_gps_rise) begin
                  w_phase_nx = 24'd0 - w_cnt_inc;
                  w_done_nx  = 1'b1;
                  w_state_nx = IDLE;
                  w_cnt_nx   = 24'd0;
               end else if (w_loc_rise) begin
                  w_cnt_nx   = 24'd0;
               end else if (w_tmo_hit) begin
                  w_tmo_nx   = 1'b1;
                  w_state_nx = IDLE;
                  w_cnt_nx   = 24'd0;
               end
            end
            default: begin
               w_state_nx = IDLE;
               w_cnt_nx   = 24'd0;
            end
         endcase
      end
   end

   assign pm.Measure_Phase   = r_phase;
   assign pm.Measure_Done    = r_done;
   assign pm.Measure_Timeout = r_tmo;

endmodule

// File: tb/tb_phase_measure.sv
// Scoreboard bench for phase_measure: one default instance
// plus one with TIMEOUT=50, both fed the same PPS inputs.
module tb_phase_measure;

   localparam int TO = 50;

   typedef struct {
      logic [23:0] ph;
      int          cyc;
   } ev_t;

   logic CLK_SYS = 1'b0;
   logic CLK_RST = 1'b0;
   logic gps = 1'b0;
   logic loc = 1'b0;
   logic en  = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_tmo_main = 0;
   int   n_both = 0;
   ev_t  exp_q[$];
   ev_t  obs_q[$];
   ev_t  obs_to_q[$];
   int   to_tmo_q[$];
   ev_t  mon_ev;

   phase_measure_if m_if ();
   phase_measure_if t_if ();

   assign m_if.GPS_PPS   = gps;
   assign m_if.Local_PPS = loc;
   assign m_if.Meas_En   = en;
   assign t_if.GPS_PPS   = gps;
   assign t_if.Local_PPS = loc;
   assign t_if.Meas_En   = en;

   phase_measure u_dut (
      .CLK_SYS (CLK_SYS),
      .CLK_RST (CLK_RST),
      .pm      (m_if.slave)
   );

   phase_measure #(.TIMEOUT(24'(TO))) u_to (
      .CLK_SYS (CLK_SYS),
      .CLK_RST (CLK_RST),
      .pm      (t_if.slave)
   );

   always #5 CLK_SYS = ~CLK_SYS;

   always @(posedge CLK_SYS) cyc++;

   always @(negedge CLK_SYS) begin
      if (m_if.Measure_Done) begin
         mon_ev.ph  = m_if.Measure_Phase;
         mon_ev.cyc = cyc;
         obs_q.push_back(mon_ev);
      end
      if (t_if.Measure_Done) begin
         mon_ev.ph  = t_if.Measure_Phase;
         mon_ev.cyc = cyc;
         obs_to_q.push_back(mon_ev);
      end
      if (m_if.Measure_Timeout)
         n_tmo_main++;
      if (t_if.Measure_Timeout)
         to_tmo_q.push_back(cyc);
      if (m_if.Measure_Done && m_if.Measure_Timeout)
         n_both++;
      if (t_if.Measure_Done && t_if.Measure_Timeout)
         n_both++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK_SYS);
      #2;
   endtask

   task automatic push_exp(input logic [23:0] ph);
      ev_t e;
      e.ph  = ph;
      e.cyc = cyc + 3;
      exp_q.push_back(e);
   endtask

   // First source rises, second follows n cycles later.
   task automatic drive_pair(input bit gf, input int n,
                             input bit push);
      step(1);
      if (n == 0) begin
         gps = 1'b1;
         loc = 1'b1;
      end else begin
         if (gf) gps = 1'b1;
         else    loc = 1'b1;
         step(n);
         if (gf) loc = 1'b1;
         else    gps = 1'b1;
      end
      if (push)
         push_exp(gf ? 24'(n) : 24'd0 - 24'(n));
      step(4);
      gps = 1'b0;
      loc = 1'b0;
      step(4);
   endtask

   task automatic test_reset;
      CLK_RST = 1'b0;
      en  = 1'b1;
      gps = 1'b1;
      loc = 1'b1;
      step(3);
      n_cmp++;
      if (m_if.Measure_Phase !== 24'd0) begin
         n_bad++;
         $display("FAIL reset_phase: got %h want 000000",
                  m_if.Measure_Phase);
      end
      n_cmp++;
      if (m_if.Measure_Done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_done: got %b want 0",
                  m_if.Measure_Done);
      end
      n_cmp++;
      if (m_if.Measure_Timeout !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_timeout: got %b want 0",
                  m_if.Measure_Timeout);
      end
      CLK_RST = 1'b1;
      step(12);
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_bad++;
         $display("FAIL reset_high_pps: got %0d dones want 0",
                  obs_q.size());
      end
      obs_q.delete();
      gps = 1'b0;
      loc = 1'b0;
      step(6);
   endtask

   task automatic test_gps_leads;
      ev_t o, e;
      drive_pair(1'b1, 100, 1'b1);
      step(20);
      n_cmp++;
      if (m_if.Measure_Phase !== 24'h000064) begin
         n_bad++;
         $display("FAIL gps_leads_hold: got %h want 000064",
                  m_if.Measure_Phase);
      end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL gps_leads_count: got %0d want %0d",
                  obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (o.ph !== e.ph || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL gps_leads: got %h @%0d want %h @%0d",
                     o.ph, o.cyc, e.ph, e.cyc);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_local_leads;
      ev_t o, e;
      drive_pair(1'b0, 37, 1'b1);
      step(10);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL local_leads_count: got %0d want %0d",
                  obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (o.ph !== e.ph || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL local_leads: got %h @%0d want %h @%0d",
                     o.ph, o.cyc, e.ph, e.cyc);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_simultaneous;
      ev_t o, e;
      drive_pair(1'b1, 0, 1'b1);
      // GPS_FIRST, then both rise together: GPS edge ignored
      step(1);
      gps = 1'b1;
      step(4);
      gps = 1'b0;
      step(8);
      gps = 1'b1;
      loc = 1'b1;
      push_exp(24'd12);
      step(5);
      gps = 1'b0;
      loc = 1'b0;
      step(6);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL simult_count: got %0d want %0d",
                  obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (o.ph !== e.ph || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL simult: got %h @%0d want %h @%0d",
                     o.ph, o.cyc, e.ph, e.cyc);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_restart;
      ev_t o, e;
      step(1);
      gps = 1'b1;
      step(5);
      gps = 1'b0;
      step(15);
      gps = 1'b1;
      step(5);
      loc = 1'b1;
      push_exp(24'd5);
      step(5);
      gps = 1'b0;
      loc = 1'b0;
      step(6);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL restart_count: got %0d want %0d",
                  obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (o.ph !== e.ph || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL restart: got %h @%0d want %h @%0d",
                     o.ph, o.cyc, e.ph, e.cyc);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   // New GPS edge lands in the Done cycle of the previous pair.
   task automatic test_back_to_back;
      ev_t o, e;
      step(1);
      gps = 1'b1;
      step(5);
      gps = 1'b0;
      step(5);
      loc = 1'b1;
      push_exp(24'd10);
      step(1);
      gps = 1'b1;
      step(4);
      loc = 1'b0;
      step(4);
      loc = 1'b1;
      push_exp(24'd8);
      step(4);
      gps = 1'b0;
      loc = 1'b0;
      step(6);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL b2b_count: got %0d want %0d",
                  obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (o.ph !== e.ph || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL b2b: got %h @%0d want %h @%0d",
                     o.ph, o.cyc, e.ph, e.cyc);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_timeout;
      ev_t o, e;
      logic [23:0] ph0;
      int p;
      step(TO + 10);
      obs_to_q.delete();
      to_tmo_q.delete();
      ph0 = t_if.Measure_Phase;
      gps = 1'b1;
      p   = cyc;
      step(TO + 20);
      n_cmp++;
      if (to_tmo_q.size() != 1) begin
         n_bad++;
         $display("FAIL timeout_count: got %0d want 1",
                  to_tmo_q.size());
      end else begin
         n_cmp++;
         if (to_tmo_q[0] != p + TO + 3) begin
            n_bad++;
            $display("FAIL timeout_cycle: got %0d want %0d",
                     to_tmo_q[0], p + TO + 3);
         end
      end
      n_cmp++;
      if (t_if.Measure_Phase !== ph0 || obs_to_q.size() != 0) begin
         n_bad++;
         $display("FAIL timeout_hold: got %h/%0d want %h/0",
                  t_if.Measure_Phase, obs_to_q.size(), ph0);
      end
      gps = 1'b0;
      step(3);
      drive_pair(1'b1, 10, 1'b1);
      drive_pair(1'b1, TO, 1'b1);
      drive_pair(1'b1, TO + 1, 1'b1);
      n_cmp++;
      if (obs_to_q.size() != 2) begin
         n_bad++;
         $display("FAIL to_done_count: got %0d want 2",
                  obs_to_q.size());
      end
      for (int i = 0; i < obs_to_q.size() && i < 2; i++) begin
         n_cmp++;
         if (obs_to_q[i].ph !== exp_q[i].ph ||
             obs_to_q[i].cyc != exp_q[i].cyc) begin
            n_bad++;
            $display("FAIL to_done: got %h @%0d want %h @%0d",
                     obs_to_q[i].ph, obs_to_q[i].cyc,
                     exp_q[i].ph, exp_q[i].cyc);
         end
      end
      n_cmp++;
      if (to_tmo_q.size() != 2) begin
         n_bad++;
         $display("FAIL to_tmo51_count: got %0d want 2",
                  to_tmo_q.size());
      end else if (to_tmo_q[1] != exp_q[2].cyc - 1) begin
         n_bad++;
         $display("FAIL to_tmo51_cycle: got %0d want %0d",
                  to_tmo_q[1], exp_q[2].cyc - 1);
      end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL timeout_main_count: got %0d want %0d",
                  obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (o.ph !== e.ph || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL timeout_main: got %h @%0d want %h @%0d",
                     o.ph, o.cyc, e.ph, e.cyc);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_enable;
      ev_t o, e;
      en = 1'b0;
      drive_pair(1'b1, 5, 1'b0);
      en = 1'b1;
      step(3);
      // Disabled mid-measurement: silently discarded
      gps = 1'b1;
      step(10);
      en = 1'b0;
      step(2);
      loc = 1'b1;
      step(4);
      en = 1'b1;
      step(3);
      gps = 1'b0;
      loc = 1'b0;
      step(4);
      // Edge seen in the first enabled cycle is accepted
      en = 1'b0;
      step(1);
      gps = 1'b1;
      step(2);
      en = 1'b1;
      step(4);
      loc = 1'b1;
      push_exp(24'd6);
      step(4);
      gps = 1'b0;
      loc = 1'b0;
      step(6);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL enable_count: got %0d want %0d",
                  obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (o.ph !== e.ph || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL enable: got %h @%0d want %h @%0d",
                     o.ph, o.cyc, e.ph, e.cyc);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_abort;
      ev_t o, e;
      step(1);
      gps = 1'b1;
      step(13);
      CLK_RST = 1'b0;
      #1;
      n_cmp++;
      if (m_if.Measure_Phase !== 24'd0 ||
          m_if.Measure_Done !== 1'b0 ||
          m_if.Measure_Timeout !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_outputs: got %h/%b/%b want 0/0/0",
                  m_if.Measure_Phase, m_if.Measure_Done,
                  m_if.Measure_Timeout);
      end
      step(2);
      CLK_RST = 1'b1;
      step(5);
      gps = 1'b0;
      step(5);
      drive_pair(1'b1, 7, 1'b1);
      step(4);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL abort_count: got %0d want %0d",
                  obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (o.ph !== e.ph || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL abort: got %h @%0d want %h @%0d",
                     o.ph, o.cyc, e.ph, e.cyc);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_no_overlap;
      n_cmp++;
      if (n_both != 0) begin
         n_bad++;
         $display("FAIL done_and_timeout: got %0d want 0",
                  n_both);
      end
      n_cmp++;
      if (n_tmo_main != 0) begin
         n_bad++;
         $display("FAIL main_timeout: got %0d want 0",
                  n_tmo_main);
      end
   endtask

   initial begin
      test_reset();
      test_gps_leads();
      test_local_leads();
      test_simultaneous();
      test_restart();
      test_back_to_back();
      test_timeout();
      test_enable();
      test_reset_abort();
      test_no_overlap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/phase_measure.md
PHASE_MEASURE -- requirements
Module: phase_measure

Interface
REQ-001 Parameter TIMEOUT, default 24'd5000000, is the maximum wait in CLK_SYS cycles for the second edge; the legal range is 1 to 2^23-1.
REQ-002 CLK_SYS  input  1  system clock; all logic is on its rising edge.
REQ-003 CLK_RST  input  1  asynchronous active-low reset.
REQ-004 GPS_PPS  input  1  GPS pulse-per-second, asynchronous to CLK_SYS.
REQ-005 Local_PPS  input  1  locally divided oscillator PPS, asynchronous to CLK_SYS.
REQ-006 Meas_En  input  1  measurement enable; when low, no measurement runs.
REQ-007 Measure_Phase  output  24  signed phase difference in CLK_SYS cycles; positive means GPS leads, negative means Local leads.
REQ-008 Measure_Done  output  1  one-cycle pulse marking a new Measure_Phase value.
REQ-009 Measure_Timeout  output  1  one-cycle pulse marking an abandoned measurement.

Function
REQ-010 Each PPS input shall pass through a 2-FF synchronizer, then a rising-edge detector that produces a one-cycle pulse (gps_rise, loc_rise).
REQ-011 Both inputs shall have identical synchronizer latency, so relative edge timing is preserved exactly.
REQ-012 The FSM shall have exactly three states: IDLE, GPS_FIRST and LOCAL_FIRST; the reset state is IDLE.
REQ-013 In IDLE, a gps_rise without a loc_rise shall move to GPS_FIRST and clear the counter to 0.
REQ-014 In IDLE, a loc_rise without a gps_rise shall move to LOCAL_FIRST and clear the counter to 0.
REQ-015 In IDLE, a simultaneous gps_rise and loc_rise shall load Measure_Phase with 0, pulse Measure_Done on the next cycle and stay in IDLE.
REQ-016 In GPS_FIRST or LOCAL_FIRST, the 24-bit counter shall increment by 1 every cycle; the counter value equals cycles elapsed since the first edge minus 1.
REQ-017 In GPS_FIRST, a loc_rise shall register Measure_Phase = +(counter+1), assert Measure_Done for exactly the next cycle and return to IDLE.
REQ-018 In LOCAL_FIRST, a gps_rise shall register Measure_Phase = -(counter+1) in two's complement, assert Measure_Done for exactly the next cycle and return to IDLE.
REQ-019 Latency: if the first edge is detected in cycle t0 and the second in cycle t1, |Measure_Phase| = t1-t0, and Measure_Done is high in cycle t1+1.
REQ-020 In GPS_FIRST, a repeated gps_rise without a loc_rise shall restart the count: counter to 0, state unchanged, no pulse.
REQ-021 In LOCAL_FIRST, a repeated loc_rise without a gps_rise shall restart the count: counter to 0, state unchanged, no pulse.
REQ-022 In GPS_FIRST or LOCAL_FIRST, a simultaneous gps_rise and loc_rise shall complete the measurement per REQ-017 or REQ-018; the extra edge of the first source is ignored.
REQ-023 When counter+1 reaches TIMEOUT without the completing edge, the block shall pulse Measure_Timeout for the next cycle and return to IDLE, leaving Measure_Phase unchanged.
REQ-024 A completing edge in the same cycle as the timeout condition shall take priority and produce Measure_Done, not Measure_Timeout.
REQ-025 The cycle in which Measure_Done is high shall be IDLE, and an edge in that cycle shall start a new measurement.
REQ-026 Measure_Phase shall hold its value between Measure_Done pulses.
REQ-027 Measure_Done and Measure_Timeout shall never be high in the same cycle.
REQ-028 Meas_En low shall force IDLE and clear the counter, with no pulses generated; edges shall be accepted from the first cycle Meas_En is high.
REQ-029 Deasserting Meas_En mid-measurement shall discard that measurement silently.
REQ-030 All outputs shall be registered.

Reset
REQ-031 CLK_RST low shall immediately set state IDLE, counter 0, Measure_Phase 0, Measure_Done 0, Measure_Timeout 0, and all synchronizer and edge flops 0.
REQ-032 Reset asserted mid-measurement shall abort it with no pulse.
REQ-033 After reset release, a PPS input already high shall not produce an edge until it has gone low and then high again.

Verification
REQ-034 GPS rises, Local rises 100 cycles later -> Measure_Phase = +100 (24'h000064), one Done pulse.
REQ-035 Local rises, GPS rises 37 cycles later -> Measure_Phase = -37 (24'hFFFFDB), one Done pulse.
REQ-036 Both inputs rise on the same CLK_SYS edge -> Measure_Phase = 0, Done pulse 3 cycles after the input edge (synchronizer plus registration).
REQ-037 TIMEOUT=50, GPS rises and Local stays low -> Measure_Timeout pulses once, 50 cycles after gps_rise, Measure_Phase unchanged; a later pair at offset 10 yields +10.
REQ-038 GPS rises, GPS rises again 20 cycles later, then Local rises 5 cycles after that -> Measure_Phase = +5.
REQ-039 CLK_RST pulsed low 10 cycles into GPS_FIRST -> no Done, all outputs 0; the next pair at offset 7 yields +7.
